// File: rtl/sseg_word_reader.sv
// -----------------------------------------------------------------------------
// sseg_word_reader
//
// Watches a multiplexed 4-digit seven-segment display bus, rebuilds each
// complete scan into a 32-bit frame and decodes it into a 3-bit word code.
// The frame is offered to a consumer through a valid/ready handshake.
//
// Parameters:
//   STABLE_CYCLES  : consecutive identical samples needed to accept a digit
//   TIMEOUT_CYCLES : idle cycles after which a partial frame is discarded
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   seg[7:0]   in   segment bus, active-low, seg[0] = dp
//   an[3:0]    in   anode bus, active-low, 4'b1110 = digit 0 (leftmost)
//   digits     out  last complete frame, digit n in bits [8n+7:8n]
//   word       out  decoded word code (0, 1, 7 or 6 for anything else)
//   word_valid out  digits/word hold an unconsumed frame
//   word_ready in   consumer accepts the frame
//   overrun    out  sticky: a frame arrived while the previous one was held
//   an_error   out  sticky: anode bus showed other than exactly one low bit
//   stale      out  sticky: a partial frame timed out
//
// Build option:
//   SSEG_CHANGE_ONLY_EN  when defined, frames decoding to the word already
//                        reported are silently dropped.
// -----------------------------------------------------------------------------
module sseg_word_reader #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [31:0] digits,
    output logic [2:0]  word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        overrun,
    output logic        an_error,
    output logic        stale
);

    localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        ST_COLLECT,
        ST_HOLD
    } state_t;

    state_t r_state;

    // Two-flop synchronizers
    logic [7:0]     r_seg_s1, r_seg_s2;
    logic [3:0]     r_an_s1, r_an_s2;
    logic [1:0]     r_sync_fill;

    // Stability tracking
    logic [11:0]    r_prev;
    logic [SCW-1:0] r_stab_cnt;

    // Frame assembly
    logic [31:0]    r_buf;
    logic [3:0]     r_seen;
    logic [TCW-1:0] r_to_cnt;

    logic           w_an_ok;
    logic [1:0]     w_idx;
    logic           w_live;
    logic           w_sample_ok;
    logic           w_same;
    logic           w_accept;
    logic [3:0]     w_seen_set;
    logic           w_frame_done;
    logic [31:0]    w_frame;
    logic [2:0]     w_code;
    logic           w_report;

    function automatic logic [2:0] decode_word(input logic [31:0] f);
        logic [2:0] code;
        case (f)
            32'h85030341: code = 3'd0;
            32'h614903F3: code = 3'd1;
            32'hFFFFFFFF: code = 3'd7;
            default:      code = 3'd6;
        endcase
        return code;
    endfunction

    // Exactly one active-low anode selects the digit index.
    always_comb begin
        w_an_ok = 1'b0;
        w_idx   = 2'd0;
        case (r_an_s2)
            4'b1110: begin w_an_ok = 1'b1; w_idx = 2'd0; end
            4'b1101: begin w_an_ok = 1'b1; w_idx = 2'd1; end
            4'b1011: begin w_an_ok = 1'b1; w_idx = 2'd2; end
            4'b0111: begin w_an_ok = 1'b1; w_idx = 2'd3; end
            default: begin w_an_ok = 1'b0; w_idx = 2'd0; end
        endcase
    end

    // The synchronizer's reset contents are not real bus observations, so
    // samples are only used once real data has shifted through both flops.
    assign w_live      = r_sync_fill[1];
    assign w_sample_ok = w_live && w_an_ok;
    assign w_same      = w_sample_ok && ({r_an_s2, r_seg_s2} == r_prev);

    // The counter saturates at STABLE_CYCLES, so this matches on one edge only
    // per run of identical samples.
    assign w_accept     = w_same && (r_stab_cnt == SCW'(STABLE_CYCLES - 1));
    assign w_seen_set   = r_seen | (4'b0001 << w_idx);
    assign w_frame_done = w_accept && (w_seen_set == 4'hF);

    // Frame as it stands after this edge's write, so a completing digit is
    // included in the frame that gets reported.
    always_comb begin
        w_frame = r_buf;
        if (w_accept) begin
            w_frame[{w_idx, 3'b000} +: 8] = r_seg_s2;
        end
    end

    assign w_code = decode_word(w_frame);

`ifdef SSEG_CHANGE_ONLY_EN
    // word holds the last reported code; 7 after reset.
    assign w_report = w_frame_done && (w_code != word);
`else
    assign w_report = w_frame_done;
`endif

    // Synchronizers, digit acceptance, frame buffer and partial-frame timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_s1    <= 8'hFF;
            r_seg_s2    <= 8'hFF;
            r_an_s1     <= 4'hF;
            r_an_s2     <= 4'hF;
            r_sync_fill <= '0;
            r_prev      <= '1;
            r_stab_cnt  <= '0;
            r_buf       <= '1;
            r_seen      <= '0;
            r_to_cnt    <= '0;
            an_error    <= 1'b0;
            stale       <= 1'b0;
        end else begin
            r_seg_s1    <= seg;
            r_seg_s2    <= r_seg_s1;
            r_an_s1     <= an;
            r_an_s2     <= r_an_s1;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
            r_prev      <= {r_an_s2, r_seg_s2};

            if (w_live && !w_an_ok) begin
                an_error <= 1'b1;
            end

            if (!w_same) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != SCW'(STABLE_CYCLES)) begin
                r_stab_cnt <= r_stab_cnt + SCW'(1);
            end

            if (w_accept) begin
                r_buf    <= w_frame;
                r_to_cnt <= '0;
                r_seen   <= w_frame_done ? 4'h0 : w_seen_set;
            end else if (r_seen == 4'h0) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                r_to_cnt <= '0;
                r_seen   <= '0;
                stale    <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + TCW'(1);
            end
        end
    end

    // Output handshake FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            digits     <= '1;
            word       <= 3'd7;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_report) begin
                        digits     <= w_frame;
                        word       <= w_code;
                        word_valid <= 1'b1;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (word_ready) begin
                        if (w_report) begin
                            digits     <= w_frame;
                            word       <= w_code;
                            word_valid <= 1'b1;
                        end else begin
                            word_valid <= 1'b0;
                            r_state    <= ST_COLLECT;
                        end
                    end else if (w_report) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_COLLECT;
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sseg_word_reader.md
SSEG_WORD_READER -- requirements
Module: sseg_word_reader

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples required to accept a digit.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 1048576: cycles without an accepted digit before the partial frame is discarded.
REQ-003 The module SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port seg, input, 8 bits: observed segment bus, active-low, seg[0] = dp.
REQ-006 The module SHALL have port an, input, 4 bits: observed anode bus, active-low; 4'b1110 = digit 0 (leftmost), 4'b0111 = digit 3.
REQ-007 The module SHALL have port digits, output, 32 bits: last complete frame; digit n in bits [8n+7:8n].
REQ-008 The module SHALL have port word, output, 3 bits: decoded word code.
REQ-009 The module SHALL have port word_valid, output, 1 bit: word/digits hold an unconsumed frame.
REQ-010 The module SHALL have port word_ready, input, 1 bit: consumer accepts the frame.
REQ-011 The module SHALL have ports overrun, an_error and stale, each output, 1 bit, sticky status.

Function
REQ-012 seg and an SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A synchronized sample SHALL be valid only when exactly one an bit is 0; any other an value SHALL set an_error, reset the stability counter and accept nothing.
REQ-014 A digit SHALL be accepted on the edge where the valid {an,seg} sample has equalled its predecessor for STABLE_CYCLES consecutive cycles; it is accepted once, not again until the sample changes.
REQ-015 Acceptance SHALL write seg into the frame buffer at the digit index and set that digit's seen bit; a re-accepted index SHALL overwrite its entry.
REQ-016 The FSM SHALL have states COLLECT (reset state) and HOLD; collection SHALL continue in both states.
REQ-017 A frame SHALL complete on the edge the fourth seen bit sets; seen bits SHALL clear on that edge.
REQ-018 Frame decode, digit 0..3: 41,03,03,85 hex -> word 0; F3,03,49,61 hex -> word 1; FF,FF,FF,FF hex -> word 7; anything else -> word 6.
REQ-019 In COLLECT, a complete frame SHALL load digits/word and assert word_valid on the next cycle, entering HOLD.
REQ-020 In HOLD, word_valid AND word_ready SHALL complete the handshake; with no new frame that edge, word_valid SHALL clear and the FSM SHALL return to COLLECT.
REQ-021 Handshake and frame completion on the same edge SHALL load the new frame and keep word_valid high, without setting overrun.
REQ-022 Frame completion in HOLD without word_ready SHALL drop the new frame, set overrun and leave outputs unchanged.
REQ-023 If TIMEOUT_CYCLES elapse with no accepted digit and any seen bit set, seen bits SHALL clear and stale SHALL set.
REQ-024 Sticky flags SHALL clear only on reset.

Reset
REQ-025 rst high SHALL immediately force: FSM COLLECT, seen bits 0, counters 0, synchronizers to seg=FF/an=F hex, digits=FFFFFFFF hex, word=7, word_valid=0, overrun=0, an_error=0, stale=0; any partial frame or pending handshake is discarded.

Configuration
REQ-026 With SSEG_CHANGE_ONLY_EN defined, a completed frame whose word equals the last reported word SHALL be discarded without affecting word_valid or overrun; word 7 after reset counts as reported.
REQ-027 Without SSEG_CHANGE_ONLY_EN, every completed frame SHALL be reported per REQ-019..022.

Verification
REQ-028 Scan word 0 patterns, each digit held 20 cycles, word_ready=1 -> word=0, digits=85030341 hex, word_valid high exactly 1 cycle.
REQ-029 Scan word 1 twice, word_ready=0 -> first frame held with word=1, overrun=1 after second frame; raise word_ready -> word_valid falls next edge.
REQ-030 Drive an=4'b1100 for 5 cycles mid-scan -> an_error=1, no digit accepted during glitch; frame still completes after clean rescan.
REQ-031 Digits held 10 cycles (below STABLE_CYCLES) -> no acceptance, no word_valid; with TIMEOUT_CYCLES=64, three digits then silence -> stale=1 after 64 cycles.
REQ-032 Assert rst while word_valid=1 and two seen bits set -> all outputs at REQ-025 values same cycle; one clean scan afterward yields exactly one frame.
REQ-033 With SSEG_CHANGE_ONLY_EN, blank scans after reset -> no word_valid; then word 0 scan -> one report; repeat word 0 -> none.
